// File: rtl/rfifo_result_arbiter_if.sv
// Result-arbiter signal bundle: source strobes in, result-FIFO write port and drop status out.
// slave is the arbiter side; master is the sources / result-FIFO side.
interface rfifo_result_arbiter_if #(
  parameter int N_SRC        = 3,
  parameter int RESULT_WIDTH = 32,
  parameter int CNT_WIDTH    = 16
);
  logic [N_SRC*RESULT_WIDTH-1:0] src_data;
  logic [N_SRC-1:0]              src_wr;
  logic [RESULT_WIDTH-1:0]       rfifo_data;
  logic                          rfifo_wr_en;
  logic                          rfifo_full;
  logic [N_SRC-1:0]              overflow;
  logic [N_SRC*CNT_WIDTH-1:0]    drop_count;
  logic                          pending;

  modport slave (
    input  src_data, src_wr, rfifo_full,
    output rfifo_data, rfifo_wr_en, overflow, drop_count, pending
  );

  modport master (
    output src_data, src_wr, rfifo_full,
    input  rfifo_data, rfifo_wr_en, overflow, drop_count, pending
  );
endinterface

// File: rtl/rfifo_result_arbiter.sv
// Round-robin merge of per-source result buffers into one result-FIFO write port.
// Latency 2 cycles strobe-to-write; stalls on rfifo_full, sources never stall (drops flagged and counted).

module rfifo_result_arbiter_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_empty,
  output logic             o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Extra pointer bit: equal low bits with differing MSB means full.
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok   = i_pop & ~o_empty & ~i_clr;
  assign w_push_ok  = i_push & (~w_full | w_pop_ok) & ~i_clr;
  assign o_drop     = i_push & w_full & ~w_pop_ok & ~i_clr;
  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end
endmodule

module rfifo_result_arbiter #(
  parameter int N_SRC        = 3,
  parameter int RESULT_WIDTH = 32,
  parameter int DEPTH        = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 i_clock,
  input  logic                 i_resetn,
  input  logic                 i_init,
  rfifo_result_arbiter_if.slave bus
);
  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]           w_empty;
  logic [N_SRC-1:0]           w_drop;
  logic [N_SRC-1:0]           w_pop;
  logic [RESULT_WIDTH-1:0]    w_head_dat [N_SRC];

  logic                       r_out_vld;
  logic [RESULT_WIDTH-1:0]    r_out_dat;
  logic [PW-1:0]              r_rr_ptr;
  logic [N_SRC-1:0]           r_overflow;
  logic [CNT_WIDTH-1:0]       r_drop_cnt [N_SRC];

  logic                       w_wr_en;
  logic                       w_can_load;
  logic                       w_grant_vld;
  logic [PW-1:0]              w_grant_idx;
  logic [PW-1:0]              w_cand;
  logic [N_SRC*CNT_WIDTH-1:0] w_drop_count;

  for (genvar g = 0; g < N_SRC; g++) begin : g_buf
    rfifo_result_arbiter_buf #(
      .WIDTH (RESULT_WIDTH),
      .DEPTH (DEPTH)
    ) u_buf (
      .i_clk      (i_clock),
      .i_rst_n    (i_resetn),
      .i_clr      (i_init),
      .i_push     (bus.src_wr[g]),
      .i_push_dat (bus.src_data[g*RESULT_WIDTH +: RESULT_WIDTH]),
      .i_pop      (w_pop[g]),
      .o_head_dat (w_head_dat[g]),
      .o_empty    (w_empty[g]),
      .o_drop     (w_drop[g])
    );
  end

  assign w_wr_en    = r_out_vld & ~bus.rfifo_full;
  assign w_can_load = ~r_out_vld | w_wr_en;

  // First non-empty buffer after the last grant; same-cycle pushes are not yet visible.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = r_rr_ptr;
    w_cand      = r_rr_ptr;
    for (int k = 1; k <= N_SRC; k++) begin
      w_cand = PW'((int'(r_rr_ptr) + k) % N_SRC);
      if (!w_grant_vld && !w_empty[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_pop[i] = w_can_load & w_grant_vld & (w_grant_idx == PW'(i));
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_rr_ptr  <= PW'(N_SRC - 1);
    end else if (i_init) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_rr_ptr  <= PW'(N_SRC - 1);
    end else if (w_can_load) begin
      r_out_vld <= w_grant_vld;
      if (w_grant_vld) begin
        r_out_dat <= w_head_dat[w_grant_idx];
        r_rr_ptr  <= w_grant_idx;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_overflow <= '0;
      for (int i = 0; i < N_SRC; i++) r_drop_cnt[i] <= '0;
    end else if (i_init) begin
      r_overflow <= '0;
      for (int i = 0; i < N_SRC; i++) r_drop_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (w_drop[i]) begin
          r_overflow[i] <= 1'b1;
          if (r_drop_cnt[i] != '1) r_drop_cnt[i] <= r_drop_cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    w_drop_count = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_drop_count[i*CNT_WIDTH +: CNT_WIDTH] = r_drop_cnt[i];
    end
  end

  assign bus.rfifo_wr_en = w_wr_en;
  assign bus.rfifo_data  = r_out_dat;
  assign bus.overflow    = r_overflow;
  assign bus.drop_count  = w_drop_count;
  assign bus.pending     = ~(&w_empty) | r_out_vld;
endmodule

// File: tb/tb_rfifo_result_arbiter.sv
// Bench for rfifo_result_arbiter: scoreboard of expected result-FIFO writes plus per-scenario flag checks.
module tb_rfifo_result_arbiter;
  localparam int N_SRC = 3;
  localparam int RW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  logic init   = 1'b0;

  always #5 clk = ~clk;

  rfifo_result_arbiter_if #(.N_SRC(N_SRC), .RESULT_WIDTH(RW), .CNT_WIDTH(CW)) bus ();

  rfifo_result_arbiter #(
    .N_SRC        (N_SRC),
    .RESULT_WIDTH (RW),
    .DEPTH        (DEPTH),
    .CNT_WIDTH    (CW)
  ) dut (
    .i_clock  (clk),
    .i_resetn (resetn),
    .i_init   (init),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] exp_d;

  // Scoreboard: every accepted write must match the oldest expected word.
  always @(negedge clk) begin
    if (resetn && bus.rfifo_wr_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_write: got data %h, required no write", bus.rfifo_data);
      end else begin
        exp_d = exp_q.pop_front();
        if (bus.rfifo_data !== exp_d) begin
          n_bad++;
          $display("FAIL sb_data: got %h, required %h", bus.rfifo_data, exp_d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the test sequence");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    tick();
    init = 1'b1;
    bus.src_wr = '0;
    tick();
    init = 1'b0;
  endtask

  task automatic set_src(input int s, input logic [RW-1:0] d);
    bus.src_wr[s] = 1'b1;
    bus.src_data[s*RW +: RW] = d;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || bus.pending) && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || bus.pending !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d words outstanding pending=%b, required 0 and 0",
               name, exp_q.size(), bus.pending);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    bus.rfifo_full = 1'b0;
    #20;
    n_cmp++;
    if (bus.rfifo_wr_en !== 1'b0 || bus.pending !== 1'b0 || bus.rfifo_data !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got wr_en=%b pending=%b data=%h, required 0 0 0",
               bus.rfifo_wr_en, bus.pending, bus.rfifo_data);
    end
    n_cmp++;
    if (bus.overflow !== '0 || bus.drop_count !== '0) begin
      n_bad++;
      $display("FAIL reset_flags: got overflow=%b drop_count=%h, required 0 0",
               bus.overflow, bus.drop_count);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    tick();
    set_src(1, 32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rfifo_wr_en !== (cyc == 2)) begin
        n_bad++;
        $display("FAIL single_wr_en_c%0d: got %b, required %b", cyc, bus.rfifo_wr_en, (cyc == 2));
      end
      if (cyc == 3) begin
        n_cmp++;
        if (bus.pending !== 1'b0) begin
          n_bad++;
          $display("FAIL single_pending_c3: got %b, required 0", bus.pending);
        end
      end
      tick();
      bus.src_wr = '0;
    end
    wait_drain("single", 10);
  endtask

  task automatic test_simultaneous();
    do_init();
    for (int rep = 0; rep < 2; rep++) begin
      tick();
      for (int s = 0; s < N_SRC; s++) begin
        set_src(s, 32'hA000_0000 + 32'(rep * 16 + s));
        exp_q.push_back(32'hA000_0000 + 32'(rep * 16 + s));
      end
      for (int cyc = 0; cyc < 5; cyc++) begin
        @(negedge clk);
        n_cmp++;
        if (bus.rfifo_wr_en !== (cyc >= 2)) begin
          n_bad++;
          $display("FAIL simul_r%0d_wr_en_c%0d: got %b, required %b",
                   rep, cyc, bus.rfifo_wr_en, (cyc >= 2));
        end
        tick();
        bus.src_wr = '0;
      end
      wait_drain("simul", 10);
    end
  endtask

  task automatic test_backpressure();
    int writes;
    do_init();
    bus.rfifo_full = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      set_src(2, 32'hB000_0000 + 32'(k));
      if (k < DEPTH + 1) exp_q.push_back(32'hB000_0000 + 32'(k));
    end
    tick();
    bus.src_wr = '0;
    tick();
    @(negedge clk);
    n_cmp++;
    if (bus.overflow !== 3'b100 || bus.drop_count[2*CW +: CW] !== 4'd1 ||
        bus.drop_count[0 +: 2*CW] !== '0) begin
      n_bad++;
      $display("FAIL bp_drop: got overflow=%b drop_count=%h, required 100 and 100",
               bus.overflow, bus.drop_count);
    end
    n_cmp++;
    if (bus.rfifo_wr_en !== 1'b0 || bus.pending !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_stall: got wr_en=%b pending=%b, required 0 1", bus.rfifo_wr_en, bus.pending);
    end
    tick();
    bus.rfifo_full = 1'b0;
    writes = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.rfifo_wr_en === 1'b1) writes++;
      tick();
    end
    n_cmp++;
    if (writes != DEPTH + 1) begin
      n_bad++;
      $display("FAIL bp_write_count: got %0d, required %0d", writes, DEPTH + 1);
    end
    wait_drain("bp", 10);
  endtask

  task automatic test_collision();
    do_init();
    bus.rfifo_full = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      tick();
      set_src(0, 32'hC000_0000 + 32'(k));
      exp_q.push_back(32'hC000_0000 + 32'(k));
    end
    tick();
    bus.src_wr = '0;
    tick();
    bus.rfifo_full = 1'b0;
    set_src(0, 32'hC000_0000 + 32'(DEPTH + 1));
    exp_q.push_back(32'hC000_0000 + 32'(DEPTH + 1));
    @(negedge clk);
    n_cmp++;
    if (bus.rfifo_wr_en !== 1'b1) begin
      n_bad++;
      $display("FAIL coll_wr_en: got %b, required 1", bus.rfifo_wr_en);
    end
    tick();
    bus.src_wr = '0;
    wait_drain("coll", 20);
    n_cmp++;
    if (bus.drop_count[0 +: CW] !== 4'd0 || bus.overflow[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL coll_no_drop: got drop_count0=%0d overflow0=%b, required 0 0",
               bus.drop_count[0 +: CW], bus.overflow[0]);
    end
  endtask

  task automatic test_saturation();
    do_init();
    bus.rfifo_full = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      set_src(0, 32'hD000_0000 + 32'(k));
      if (k < DEPTH + 1) exp_q.push_back(32'hD000_0000 + 32'(k));
    end
    tick();
    bus.src_wr = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.drop_count[0 +: CW] !== 4'd15 || bus.overflow[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_count: got drop_count0=%0d overflow0=%b, required 15 1",
               bus.drop_count[0 +: CW], bus.overflow[0]);
    end
    tick();
    bus.rfifo_full = 1'b0;
    wait_drain("sat", 20);
    n_cmp++;
    if (bus.drop_count[0 +: CW] !== 4'd15) begin
      n_bad++;
      $display("FAIL sat_sticky: got %0d, required 15", bus.drop_count[0 +: CW]);
    end
  endtask

  task automatic fill_for_clear();
    bus.rfifo_full = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      bus.src_wr = '0;
      set_src(2, 32'hE200_0000 + 32'(k));
      if (k < 2) set_src(1, 32'hE100_0000 + 32'(k));
    end
    tick();
    bus.src_wr = '0;
  endtask

  task automatic check_cleared(input string name);
    int writes;
    n_cmp++;
    if (bus.pending !== 1'b0 || bus.rfifo_wr_en !== 1'b0 ||
        bus.overflow !== '0 || bus.drop_count !== '0) begin
      n_bad++;
      $display("FAIL %s_state: got pending=%b wr_en=%b overflow=%b drop_count=%h, required 0 0 0 0",
               name, bus.pending, bus.rfifo_wr_en, bus.overflow, bus.drop_count);
    end
    tick();
    bus.rfifo_full = 1'b0;
    writes = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.rfifo_wr_en === 1'b1) writes++;
      tick();
    end
    n_cmp++;
    if (writes != 0) begin
      n_bad++;
      $display("FAIL %s_stale_writes: got %0d, required 0", name, writes);
    end
  endtask

  task automatic test_clear_init();
    do_init();
    fill_for_clear();
    @(negedge clk);
    n_cmp++;
    if (bus.overflow !== 3'b100 || bus.pending !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_setup: got overflow=%b pending=%b, required 100 1", bus.overflow, bus.pending);
    end
    tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    @(negedge clk);
    check_cleared("clr_init");
  endtask

  task automatic test_clear_reset();
    do_init();
    fill_for_clear();
    @(negedge clk);
    resetn = 1'b0;
    bus.rfifo_full = 1'b0;
    #2;
    n_cmp++;
    if (bus.rfifo_wr_en !== 1'b0 || bus.pending !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_rst_async: got wr_en=%b pending=%b, required 0 0", bus.rfifo_wr_en, bus.pending);
    end
    bus.rfifo_full = 1'b1;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    check_cleared("clr_rst");
  endtask

  task automatic test_back_to_back();
    do_init();
    for (int cyc = 0; cyc < 15; cyc++) begin
      tick();
      bus.src_wr = '0;
      if (cyc < 12) begin
        set_src(0, 32'hF000_0000 + 32'(cyc));
        exp_q.push_back(32'hF000_0000 + 32'(cyc));
      end
      @(negedge clk);
      n_cmp++;
      if (bus.rfifo_wr_en !== (cyc >= 2 && cyc <= 13)) begin
        n_bad++;
        $display("FAIL b2b_wr_en_c%0d: got %b, required %b",
                 cyc, bus.rfifo_wr_en, (cyc >= 2 && cyc <= 13));
      end
    end
    tick();
    bus.src_wr = '0;
    wait_drain("b2b", 10);
    n_cmp++;
    if (bus.drop_count !== '0) begin
      n_bad++;
      $display("FAIL b2b_no_drop: got %h, required 0", bus.drop_count);
    end
  endtask

  initial begin
    bus.src_wr     = '0;
    bus.src_data   = '0;
    bus.rfifo_full = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_collision();
    test_saturation();
    test_clear_init();
    test_clear_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
